// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster-timing path.
//   - default 640x480@60 timing constants and derived line/frame totals
//   - 12-bit {R,G,B} packing widths
//   - test-bar colours and the bar lookup helper
//   - dly_t: one entry of the sync/blank delay line
// Optional feature macro: VGA_TEST_PATTERN_EN (adds the bar colour and its
// select flag to the delay-line entry).
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int CH_W  = 4;
    localparam int RGB_W = 3 * CH_W;

    localparam logic [RGB_W-1:0] BAR_WHITE   = 12'hFFF;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 12'h0FF;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 12'h0F0;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [RGB_W-1:0] BAR_RED     = 12'hF00;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 12'h00F;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 12'h000;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             von;
`ifdef VGA_TEST_PATTERN_EN
        logic             tp;
        logic [RGB_W-1:0] bar;
`endif
    } dly_t;

    // Idle entry: syncs inactive (high), blanked.
`ifdef VGA_TEST_PATTERN_EN
    localparam dly_t DLY_RST = '{hs: 1'b1, vs: 1'b1, von: 1'b0, tp: 1'b0, bar: '0};
`else
    localparam dly_t DLY_RST = '{hs: 1'b1, vs: 1'b1, von: 1'b0};
`endif

    // Eight 80-pixel-wide vertical bars; anything past the eighth is black.
    function automatic logic [RGB_W-1:0] bar_colour(input logic [9:0] px);
        logic [9:0] idx;
        idx = px / 10'd80;
        case (idx)
            10'd0:   bar_colour = BAR_WHITE;
            10'd1:   bar_colour = BAR_YELLOW;
            10'd2:   bar_colour = BAR_CYAN;
            10'd3:   bar_colour = BAR_GREEN;
            10'd4:   bar_colour = BAR_MAGENTA;
            10'd5:   bar_colour = BAR_RED;
            10'd6:   bar_colour = BAR_BLUE;
            default: bar_colour = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides clk by CLK_DIV to produce the pixel-rate strobe.
//   clk        system clock
//   rst        synchronous active-high reset
//   pixel_tick one-clk strobe when the divider reaches CLK_DIV-1; held low
//              while rst is asserted (so CLK_DIV=1 gives a constant high
//              strobe outside reset)
module vga_pixel_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_tick
);

    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign pixel_tick = !rst && (cnt == CNT_MAX);

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: 640x480@60 raster-timing master for the renderer.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   test_en            (VGA_TEST_PATTERN_EN only) select colour-bar pattern
//   rgb_in[11:0]       renderer colour, valid PIPE_DELAY ticks after x/y
//   x, y               raster counters presented to the renderer
//   pixel_tick         one-clk pixel strobe
//   video_on           undelayed visible-area flag
//   frame_start        strobe on the tick presenting x=0, y=0
//   hsync, vsync       active-low syncs, delayed PIPE_DELAY+1 ticks
//   vga_r/g/b          colour pins, blanked outside the delayed visible area
// Optional feature macro: VGA_TEST_PATTERN_EN.
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int PIPE_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_en,
`endif
    input  logic [RGB_W-1:0] rgb_in,
    output logic [9:0]       x,
    output logic [9:0]       y,
    output logic             pixel_tick,
    output logic             video_on,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [CH_W-1:0]  vga_r,
    output logic [CH_W-1:0]  vga_g,
    output logic [CH_W-1:0]  vga_b
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_C  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    vga_pixel_tick #(
        .CLK_DIV    (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .pixel_tick (pixel_tick)
    );

    // Raster counters: free-running through blanking, y steps on the x wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pixel_tick) begin
            if (x == H_LAST) begin
                x <= '0;
                y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    assign video_on    = (x < H_VIS_C) && (y < V_VIS_C);
    assign frame_start = pixel_tick && (x == 10'd0) && (y == 10'd0);

    // ---- stage p0: raw sync/blank decoded from the live counters ----
    dly_t raw_p0;
    dly_t dly_end;

    always_comb begin
        raw_p0     = DLY_RST;
        raw_p0.hs  = !((x >= HS_START) && (x < HS_END));
        raw_p0.vs  = !((y >= VS_START) && (y < VS_END));
        raw_p0.von = video_on;
`ifdef VGA_TEST_PATTERN_EN
        raw_p0.tp  = test_en;
        raw_p0.bar = bar_colour(x);
`endif
    end

    // ---- stage p1: PIPE_DELAY-deep delay line, advancing on pixel_tick ----
    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign dly_end = raw_p0;
        end else begin : g_dly
            dly_t dly_p1 [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        dly_p1[i] <= DLY_RST;
                    end
                end else if (pixel_tick) begin
                    dly_p1[0] <= raw_p0;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        dly_p1[i] <= dly_p1[i-1];
                    end
                end
            end

            assign dly_end = dly_p1[PIPE_DELAY-1];
        end
    endgenerate

    // ---- stage p2: pin register, sync and colour aligned ----
    logic [RGB_W-1:0] col_src;
    logic [RGB_W-1:0] rgb_p2;

    always_comb begin
`ifdef VGA_TEST_PATTERN_EN
        col_src = dly_end.tp ? dly_end.bar : rgb_in;
`else
        col_src = rgb_in;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            rgb_p2 <= '0;
        end else if (pixel_tick) begin
            hsync  <= dly_end.hs;
            vsync  <= dly_end.vs;
            rgb_p2 <= dly_end.von ? col_src : '0;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_p2;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver with a reduced raster so several
// frames fit in a short run. The reference model works on the absolute
// pixel-tick index since reset.
module tb_vga_scan_driver;

    localparam int CD = 4;
    localparam int HV = 24, HF = 4, HS = 6, HB = 5;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
    localparam int PD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic [9:0]  x, y;
    logic        pixel_tick, video_on, frame_start, hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_en = 1'b0;
`endif

    vga_scan_driver #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(PD)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .rgb_in(rgb_in),
        .x(x),
        .y(y),
        .pixel_tick(pixel_tick),
        .video_on(video_on),
        .frame_start(frame_start),
        .hsync(hsync),
        .vsync(vsync),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        bit          von;
        bit          fs;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   k = 0;
    logic rst_seen = 1'b1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // State seen during tick m; pins reflect position m-1-PD sampled with
    // the colour the renderer returned on tick m-1.
    function automatic exp_t expect_at(input int m, input logic [11:0] r);
        exp_t e;
        int p, px, py;
        e.x   = m % HT;
        e.y   = (m / HT) % VT;
        e.von = (e.x < HV) && (e.y < VV);
        e.fs  = (e.x == 0) && (e.y == 0);
        if (m - 1 >= PD) begin
            p     = m - 1 - PD;
            px    = p % HT;
            py    = (p / HT) % VT;
            e.hs  = !(px >= HV + HF && px < HV + HF + HS);
            e.vs  = !(py >= VV + VF && py < VV + VF + VS);
            e.rgb = (px < HV && py < VV) ? r : 12'h000;
        end else begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.rgb = 12'h000;
        end
        return e;
    endfunction

    task automatic start_model();
        k = 0;
        q.delete();
        q.push_back(expect_at(0, 12'h000));
    endtask

    task automatic next_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pixel_tick && n < 4 * CD);
        if (!pixel_tick) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick_timeout: got no pixel_tick in %0d clks required <= %0d", n, CD);
        end else begin
            q.push_back(expect_at(k + 1, rgb_in));
            k++;
        end
        @(posedge clk);
        #1;
        rgb_in = 12'($urandom);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_model();
    endtask

    // Monitor
    always @(posedge clk) rst_seen <= rst;

    int   since = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("rst_x", int'(x), 0);
            chk("rst_y", int'(y), 0);
            chk("rst_hsync", int'(hsync), 1);
            chk("rst_vsync", int'(vsync), 1);
            chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
            chk("rst_tick", int'(pixel_tick), 0);
            chk("rst_fs", int'(frame_start), 0);
            chk("rst_video_on", int'(video_on), 1);
            since = 1;
        end else if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries required >= 1");
        end else begin
            since++;
            cur = q[0];
            chk("x", int'(x), cur.x);
            chk("y", int'(y), cur.y);
            chk("video_on", int'(video_on), int'(cur.von));
            chk("hsync", int'(hsync), int'(cur.hs));
            chk("vsync", int'(vsync), int'(cur.vs));
            chk("rgb", int'({vga_r, vga_g, vga_b}), int'(cur.rgb));
            if (pixel_tick) begin
                chk("tick_spacing", since, CD);
                chk("frame_start", int'(frame_start), int'(cur.fs));
                void'(q.pop_front());
                since = 0;
            end else begin
                chk("frame_start_idle", int'(frame_start), 0);
                if (since > CD) begin
                    chk("tick_missing", since, CD);
                    since = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        start_model();
        // Past one frame wrap, into the vertical+horizontal sync region.
        run_ticks(FRAME + (VV + VF) * HT + HV + HF + 2 + PD + 2);
        pulse_reset();
        run_ticks(2 * FRAME + 50);
        pulse_reset();
        run_ticks(int'($urandom_range(FRAME - 1, 1)));
        pulse_reset();
        run_ticks(HT + 10);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
